bcp_ucarb: RTL and testbench
============================

Name: bcp_ucarb

Overview:
- Unit-clause arbiter sitting between the decision unit and the array of BCP PEs.
- It is the producer end of the PE literal handshake (newLit / newLitValid / newLitAccept) and the consumer of PE implications and conflicts.
- It captures per-PE implications, serialises them into the unit-clause queue (UCQ), and broadcasts queue heads to all PEs.
- It halts the PEs while captured implications are still draining, and reports conflict and quiescence to the controller.

Parameters:
- NUM_PE, 4, number of BCP PEs served.
- UCQ_DEPTH, 16, UCQ entries; power of two, at least 2.
- LIT_W, 8, width of lit_t (signed 2's-complement literal; 0 is reserved/invalid).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- dec_lit  in  LIT_W  decision literal from decision unit
- dec_valid  in  1  decision literal valid
- dec_ready  out  1  decision accepted this cycle when dec_valid=1
- pe_imply_valid  in  NUM_PE  per-PE implication valid
- pe_imply_lit  in  NUM_PE*LIT_W  per-PE implied literal, PE i at bits [i*LIT_W +: LIT_W]
- pe_conflict  in  NUM_PE  per-PE conflict
- pe_stall  in  NUM_PE  per-PE idle-and-starved indication
- pe_newLitAccept  in  NUM_PE  per-PE accept
- newLit  out  LIT_W  broadcast UCQ head
- newLitValid  out  1  UCQ non-empty and no conflict
- ucarb_halt  out  1  freeze all PEs
- conflict  out  1  sticky conflict flag
- conflict_clr  in  1  clear conflict and flush all state
- quiescent  out  1  BCP round complete

Behaviour:
- Reset (rst_n=0 at posedge): UCQ empty, pending registers empty, round-robin pointer=0, conflict=0. Resulting outputs: newLitValid=0, ucarb_halt=0, dec_ready=1. Reset mid-operation discards all queued and pending literals.
- Capture:
  - pend_v[i]/pend_lit[i] is one register per PE.
  - At a posedge with pe_imply_valid[i]=1 and ucarb_halt=0, pend_v[i]<=1 and pend_lit[i]<=pe_imply_lit[i].
  - Implications presented while halted are ignored, because a halted PE does not assert them.
- Halt: ucarb_halt = |pend_v (registered source, no combinational path from PE inputs).
- Drain:
  - Each cycle at most one pending entry is pushed into the UCQ, selected round-robin starting at rr_ptr.
  - A push occurs only if the UCQ is not full, or is full and popping this cycle.
  - On a push, the selected pend_v clears and rr_ptr becomes the selected index + 1, mod NUM_PE.
  - If the UCQ is full, pending entries hold and halt stays asserted; no loss.
- Decision push: dec_ready = !ucarb_halt && !conflict && UCQ empty && &pe_stall. Accepted decision is written to the UCQ; it never coincides with a drain push.
- Broadcast/pop:
  - newLit = UCQ head; newLitValid = !empty && !conflict.
  - Pop when newLitValid && &pe_newLitAccept && !ucarb_halt.
  - All PEs must take the same literal in the same cycle; partial accept does not pop.
- Simultaneous push and pop while full is allowed; count is unchanged. Pointers wrap mod UCQ_DEPTH.
- Conflict:
  - Any pe_conflict=1 sets conflict at the next posedge; conflict is sticky.
  - While conflict=1: newLitValid=0, dec_ready=0, and capture still clears the pipeline.
  - conflict_clr=1 empties the UCQ and pending registers and clears conflict next cycle; conflict_clr has priority over a simultaneous conflict set.
- quiescent = UCQ empty && !|pend_v && &pe_stall && !conflict (combinational).
- Literal 0 from a PE with imply_valid=1 is dropped (not captured).

Optional Feature:
- UCARB_DEDUP_EN defined:
  - Before each drain push, the literal is compared against all valid UCQ entries.
  - Exact match: the push is dropped but the pending entry still clears.
  - Negated match (lit == -entry): conflict sets next cycle.
- UCARB_DEDUP_EN undefined: duplicates are enqueued verbatim; complementary literals are left for the PEs to detect as conflicts.

Decomposition:
- lit_t, LIT_W and bcp_state_t stay in the shared BCP package. Add ucarb_rr_sel_f (round-robin select function) to the same package.
- One sub-module, bcp_ucq_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, plus a flattened content vector exposed for dedup.

Test Plan (NUM_PE=2, UCQ_DEPTH=4, LIT_W=8):
- Reset, all pe_stall=1, dec_lit=5 with dec_valid -> dec_ready=1; next cycle newLit=5, newLitValid=1; pe_newLitAccept=2'b11 -> empty, quiescent=1.
- Decision 5; PE0 accepts, PE1 does not -> no pop; newLit stays 5 until both accept.
- Same-cycle pe_imply PE0=-3, PE1=7 -> halt=1 for 2 cycles; UCQ order -3 then 7; rr_ptr=0 afterwards.
- UCQ holding 4 entries plus a pending 9 -> halt held; one pop frees a slot and 9 enters the same cycle; count stays 4.
- pe_conflict[1]=1 with 2 entries queued -> conflict=1, newLitValid=0; conflict_clr -> empty, conflict=0.
- UCARB_DEDUP_EN: UCQ holds 4; implication 4 is dropped; implication -4 sets conflict.

Source files
------------

// File: rtl/bcp_pkg.sv
// ---------------------------------------------------------------------------
// bcp_pkg : shared BCP definitions.
//   LIT_W / lit_t   : literal width and signed literal type (0 is invalid)
//   bcp_state_t     : BCP controller phase encoding
//   rr_sel_t        : result of a round-robin pick (found flag + index)
//   ucarb_rr_sel_f  : round-robin select over up to RR_MAX requesters
// ---------------------------------------------------------------------------
package bcp_pkg;

  localparam int LIT_W = 8;
  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    BCP_IDLE      = 2'd0,
    BCP_DECIDE    = 2'd1,
    BCP_PROPAGATE = 2'd2,
    BCP_CONFLICT  = 2'd3
  } bcp_state_t;

  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_sel_t;

  // First set bit of req[n-1:0], searching upward from ptr and wrapping at n.
  function automatic rr_sel_t ucarb_rr_sel_f(input logic [RR_MAX-1:0]   req,
                                             input logic [RR_IDX_W-1:0] ptr,
                                             input int                  n);
    rr_sel_t sel;
    int      j;
    sel.found = 1'b0;
    sel.idx   = {RR_IDX_W{1'b0}};
    for (int k = 0; k < RR_MAX; k++) begin
      j = (int'(ptr) + k) % n;
      if (!sel.found && (k < n) && req[RR_IDX_W'(j)]) begin
        sel.found = 1'b1;
        sel.idx   = RR_IDX_W'(j);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/bcp_ucq_fifo.sv
// ---------------------------------------------------------------------------
// bcp_ucq_fifo : synchronous FIFO backing the unit-clause queue.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : empty the queue at the next edge
//   push/push_data, pop : enqueue / dequeue; push while full only with pop
//   head         : oldest entry
//   full, empty, count : occupancy
//   contents     : raw storage, slot j at [j*W +: W]
//   valid_mask   : bit j set when storage slot j holds a live entry
// ---------------------------------------------------------------------------
module bcp_ucq_fifo
  import bcp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH*W-1:0]     contents,
  output logic [DEPTH-1:0]       valid_mask
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem_r[j] <= {W{1'b0}};
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Flattened storage view plus liveness of each slot relative to the head.
  always_comb begin
    contents   = {(DEPTH*W){1'b0}};
    valid_mask = {DEPTH{1'b0}};
    for (int j = 0; j < DEPTH; j++) begin
      contents[j*W +: W] = mem_r[j];
      valid_mask[j]      = ({1'b0, AW'(j) - rd_ptr_r} < count_r);
    end
  end

endmodule

// File: rtl/bcp_ucarb.sv
// ---------------------------------------------------------------------------
// bcp_ucarb : unit-clause arbiter between the decision unit and the BCP PEs.
//   clk, rst_n                 : clock, synchronous active-low reset
//   dec_lit/dec_valid/dec_ready: decision literal handshake
//   pe_imply_valid/pe_imply_lit: per-PE implications (PE i at [i*LIT_W +: LIT_W])
//   pe_conflict, pe_stall      : per-PE conflict and idle-and-starved flags
//   pe_newLitAccept            : per-PE accept of the broadcast literal
//   newLit/newLitValid         : broadcast UCQ head
//   ucarb_halt                 : freeze PEs while captured implications drain
//   conflict/conflict_clr      : sticky conflict flag and full flush
//   quiescent                  : BCP round complete
// Build option: define UCARB_DEDUP_EN to drop duplicate implications and
// flag a conflict when an implication is the complement of a queued literal.
// ---------------------------------------------------------------------------
module bcp_ucarb #(
  parameter int NUM_PE    = 4,
  parameter int UCQ_DEPTH = 16,
  parameter int LIT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LIT_W-1:0]        dec_lit,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [NUM_PE-1:0]       pe_imply_valid,
  input  logic [NUM_PE*LIT_W-1:0] pe_imply_lit,
  input  logic [NUM_PE-1:0]       pe_conflict,
  input  logic [NUM_PE-1:0]       pe_stall,
  input  logic [NUM_PE-1:0]       pe_newLitAccept,
  output logic [LIT_W-1:0]        newLit,
  output logic                    newLitValid,
  output logic                    ucarb_halt,
  output logic                    conflict,
  input  logic                    conflict_clr,
  output logic                    quiescent
);

  import bcp_pkg::*;

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(UCQ_DEPTH) + 1;

  logic [NUM_PE-1:0]        pend_v_r;
  logic [LIT_W-1:0]         pend_lit_r [NUM_PE];
  logic [PTR_W-1:0]         rr_ptr_r;
  logic                     conflict_r;

  logic [RR_MAX-1:0]        req_pad_s;
  rr_sel_t                  rr_sel_s;
  logic [PTR_W-1:0]         sel_idx_s;
  logic [LIT_W-1:0]         sel_lit_s;
  logic [PTR_W-1:0]         next_rr_s;

  logic [LIT_W-1:0]         ucq_head_s;
  logic                     ucq_full_s;
  logic                     ucq_empty_s;
  logic [CNT_W-1:0]         ucq_count_s;
  logic [UCQ_DEPTH*LIT_W-1:0] ucq_contents_s;
  logic [UCQ_DEPTH-1:0]     ucq_valid_s;
  logic                     ucq_push_s;
  logic [LIT_W-1:0]         ucq_wdata_s;

  logic                     pop_s;
  logic                     drain_s;
  logic                     drain_push_s;
  logic                     dec_fire_s;
  logic                     dup_hit_s;
  logic                     neg_hit_s;
  logic                     conflict_set_s;
  logic                     unused_s;

  bcp_ucq_fifo #(
    .DEPTH (UCQ_DEPTH),
    .W     (LIT_W)
  ) u_ucq (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (conflict_clr),
    .push       (ucq_push_s),
    .push_data  (ucq_wdata_s),
    .pop        (pop_s),
    .head       (ucq_head_s),
    .full       (ucq_full_s),
    .empty      (ucq_empty_s),
    .count      (ucq_count_s),
    .contents   (ucq_contents_s),
    .valid_mask (ucq_valid_s)
  );

  // Round-robin pick of the next pending implication to drain.
  always_comb begin
    req_pad_s             = {RR_MAX{1'b0}};
    req_pad_s[NUM_PE-1:0] = pend_v_r;
    rr_sel_s              = ucarb_rr_sel_f(req_pad_s, RR_IDX_W'(rr_ptr_r), NUM_PE);
    sel_idx_s             = rr_sel_s.idx[PTR_W-1:0];
    sel_lit_s             = pend_lit_r[sel_idx_s];
    if (sel_idx_s == PTR_W'(NUM_PE - 1)) begin
      next_rr_s = {PTR_W{1'b0}};
    end else begin
      next_rr_s = sel_idx_s + PTR_W'(1);
    end
  end

`ifdef UCARB_DEDUP_EN
  // Compare the drain candidate against every live queue entry.
  always_comb begin
    dup_hit_s = 1'b0;
    neg_hit_s = 1'b0;
    for (int j = 0; j < UCQ_DEPTH; j++) begin
      dup_hit_s = dup_hit_s | (ucq_valid_s[j] &&
                  (ucq_contents_s[j*LIT_W +: LIT_W] == sel_lit_s));
      neg_hit_s = neg_hit_s | (ucq_valid_s[j] &&
                  (ucq_contents_s[j*LIT_W +: LIT_W] == (LIT_W'(0) - sel_lit_s)));
    end
  end
  assign unused_s = ^{ucq_count_s, rr_sel_s};
`else
  assign dup_hit_s = 1'b0;
  assign neg_hit_s = 1'b0;
  assign unused_s  = ^{ucq_count_s, rr_sel_s, ucq_contents_s, ucq_valid_s};
`endif

  assign ucarb_halt  = |pend_v_r;
  assign conflict    = conflict_r;
  assign newLit      = ucq_head_s;
  assign newLitValid = !ucq_empty_s && !conflict_r;
  // Halted PEs normally hold the head, but a full queue with implications
  // waiting must still be able to pop or the drain would never progress.
  assign pop_s       = newLitValid && (&pe_newLitAccept) && (!ucarb_halt || ucq_full_s);
  assign drain_s     = rr_sel_s.found && (!ucq_full_s || pop_s);
  assign drain_push_s   = drain_s && !dup_hit_s;
  assign conflict_set_s = (|pe_conflict) || (drain_s && neg_hit_s);
  // Decisions need an empty queue and no halt, so they never collide with a drain.
  assign dec_ready   = !ucarb_halt && !conflict_r && ucq_empty_s && (&pe_stall);
  assign dec_fire_s  = dec_valid && dec_ready;
  assign ucq_push_s  = dec_fire_s || drain_push_s;
  assign ucq_wdata_s = dec_fire_s ? dec_lit : sel_lit_s;
  assign quiescent   = ucq_empty_s && !ucarb_halt && (&pe_stall) && !conflict_r;

  // Pending registers: capture when running, drain one per cycle when halted.
  always_ff @(posedge clk) begin
    if (!rst_n || conflict_clr) begin
      pend_v_r <= {NUM_PE{1'b0}};
      for (int i = 0; i < NUM_PE; i++) pend_lit_r[i] <= {LIT_W{1'b0}};
    end else if (ucarb_halt) begin
      if (drain_s) pend_v_r[sel_idx_s] <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        // Literal 0 is reserved and never captured.
        if (pe_imply_valid[i] && (pe_imply_lit[i*LIT_W +: LIT_W] != {LIT_W{1'b0}})) begin
          pend_v_r[i]   <= 1'b1;
          pend_lit_r[i] <= pe_imply_lit[i*LIT_W +: LIT_W];
        end
      end
    end
  end

  // Round-robin pointer moves past the entry just drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else if (!conflict_clr && drain_s) begin
      rr_ptr_r <= next_rr_s;
    end
  end

  // Sticky conflict; the clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!rst_n || conflict_clr) begin
      conflict_r <= 1'b0;
    end else if (conflict_set_s) begin
      conflict_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcp_ucarb.sv
module tb_bcp_ucarb;

  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [LW-1:0]   dec_lit;
  logic            dec_valid;
  logic            dec_ready;
  logic [NP-1:0]   pe_imply_valid;
  logic [NP*LW-1:0] pe_imply_lit;
  logic [NP-1:0]   pe_conflict;
  logic [NP-1:0]   pe_stall;
  logic [NP-1:0]   pe_newLitAccept;
  logic [LW-1:0]   newLit;
  logic            newLitValid;
  logic            ucarb_halt;
  logic            conflict;
  logic            conflict_clr;
  logic            quiescent;

  always #5 clk = ~clk;

  bcp_ucarb #(.NUM_PE(NP), .UCQ_DEPTH(DEPTH), .LIT_W(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dec_lit         (dec_lit),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .pe_imply_valid  (pe_imply_valid),
    .pe_imply_lit    (pe_imply_lit),
    .pe_conflict     (pe_conflict),
    .pe_stall        (pe_stall),
    .pe_newLitAccept (pe_newLitAccept),
    .newLit          (newLit),
    .newLitValid     (newLitValid),
    .ucarb_halt      (ucarb_halt),
    .conflict        (conflict),
    .conflict_clr    (conflict_clr),
    .quiescent       (quiescent)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit model_ok = 1'b0;

  // Reference model: a literal queue, one pending slot per PE, a rotation start, a flag.
  logic [LW-1:0] mq[$];
  bit            m_pv[NP];
  logic [LW-1:0] m_pl[NP];
  int            m_rr;
  bit            m_conf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_halt();
    bit h;
    h = 1'b0;
    for (int i = 0; i < NP; i++) h = h | m_pv[i];
    return h;
  endfunction

  task automatic check_outputs(input string ph);
    bit h;
    bit nlv;
    bit empty;
    h     = m_halt();
    empty = (mq.size() == 0);
    nlv   = !empty && !m_conf;
    check_eq({ph, "_halt"}, 32'(ucarb_halt), 32'(h));
    check_eq({ph, "_nlv"}, 32'(newLitValid), 32'(nlv));
    if (nlv) check_eq({ph, "_newlit"}, 32'(newLit), 32'(mq[0]));
    check_eq({ph, "_decrdy"}, 32'(dec_ready), 32'(!h && !m_conf && empty && (&pe_stall)));
    check_eq({ph, "_quiet"}, 32'(quiescent), 32'(empty && !h && (&pe_stall) && !m_conf));
    check_eq({ph, "_conf"}, 32'(conflict), 32'(m_conf));
  endtask

  task automatic model_update();
    bit            h, full, pop, found, setc, dup, neg, dec_take;
    int            idx;
    logic [LW-1:0] lit;
    h        = m_halt();
    full     = (mq.size() == DEPTH);
    pop      = (mq.size() > 0) && !m_conf && (&pe_newLitAccept) && (!h || full);
    dec_take = dec_valid && !h && !m_conf && (mq.size() == 0) && (&pe_stall);
    if (!rst_n) begin
      mq.delete();
      for (int i = 0; i < NP; i++) m_pv[i] = 1'b0;
      m_rr     = 0;
      m_conf   = 1'b0;
      model_ok = 1'b1;
      return;
    end
    if (conflict_clr) begin
      mq.delete();
      for (int i = 0; i < NP; i++) m_pv[i] = 1'b0;
      m_conf = 1'b0;
      return;
    end
    setc  = |pe_conflict;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NP; k++) begin
      if (!found && m_pv[(m_rr + k) % NP]) begin
        found = 1'b1;
        idx   = (m_rr + k) % NP;
      end
    end
    if (found && (!full || pop)) begin
      lit = m_pl[idx];
      dup = 1'b0;
      neg = 1'b0;
`ifdef UCARB_DEDUP_EN
      foreach (mq[j]) begin
        if (mq[j] == lit) dup = 1'b1;
        if (mq[j] == LW'(8'd0 - lit)) neg = 1'b1;
      end
`endif
      if (neg) setc = 1'b1;
      m_pv[idx] = 1'b0;
      m_rr      = (idx + 1) % NP;
      if (pop) begin
        void'(mq.pop_front());
        pop = 1'b0;
      end
      if (!dup) mq.push_back(lit);
    end
    if (pop) void'(mq.pop_front());
    if (dec_take) mq.push_back(dec_lit);
    if (!h) begin
      for (int i = 0; i < NP; i++) begin
        if (pe_imply_valid[i] && (pe_imply_lit[i*LW +: LW] != 8'd0)) begin
          m_pv[i] = 1'b1;
          m_pl[i] = pe_imply_lit[i*LW +: LW];
        end
      end
    end
    m_conf = m_conf | setc;
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input string ph);
    @(negedge clk);
    if (model_ok) check_outputs(ph);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid       = 1'b0;
    dec_lit         = 8'd0;
    pe_imply_valid  = 2'b00;
    pe_imply_lit    = 16'd0;
    pe_conflict     = 2'b00;
    pe_stall        = 2'b11;
    pe_newLitAccept = 2'b00;
    conflict_clr    = 1'b0;
  endtask

  task automatic imply2(input logic [1:0] v, input logic [7:0] l1, input logic [7:0] l0);
    pe_imply_valid = v;
    pe_imply_lit   = {l1, l0};
    cycle("imp");
    pe_imply_valid = 2'b00;
    cycle("drn");
    cycle("drn");
  endtask

  function automatic logic [7:0] rand_lit();
    return 8'($urandom_range(0, 8)) - 8'd4;
  endfunction

  initial begin
    logic [7:0] exp_order [4];
    exp_order[0] = 8'd2; exp_order[1] = 8'd3; exp_order[2] = 8'd4; exp_order[3] = 8'd9;

    rst_n = 1'b0;
    idle_inputs();
    cycle("rst");
    cycle("rst");
    rst_n = 1'b1;
    #1;
    check_eq("rst_nlv", 32'(newLitValid), 32'd0);
    check_eq("rst_halt", 32'(ucarb_halt), 32'd0);

    // Decision 5, partial accept holds the head, full accept pops.
    dec_lit = 8'd5; dec_valid = 1'b1; #1;
    check_eq("tp1_decrdy", 32'(dec_ready), 32'd1);
    cycle("tp1");
    dec_valid = 1'b0; #1;
    check_eq("tp1_nlv", 32'(newLitValid), 32'd1);
    check_eq("tp1_newlit", 32'(newLit), 32'd5);
    pe_newLitAccept = 2'b01;
    cycle("tp2");
    cycle("tp2");
    #1;
    check_eq("tp2_hold", 32'(newLit), 32'd5);
    check_eq("tp2_nlv", 32'(newLitValid), 32'd1);
    pe_newLitAccept = 2'b11;
    cycle("tp1pop");
    pe_newLitAccept = 2'b00; #1;
    check_eq("tp1_empty", 32'(newLitValid), 32'd0);
    check_eq("tp1_quiet", 32'(quiescent), 32'd1);

    // Same-cycle implications -3 (PE0) and 7 (PE1).
    pe_imply_valid = 2'b11; pe_imply_lit = {8'd7, 8'hFD};
    cycle("tp3");
    pe_imply_valid = 2'b00; #1;
    check_eq("tp3_halt1", 32'(ucarb_halt), 32'd1);
    cycle("tp3");
    #1; check_eq("tp3_halt2", 32'(ucarb_halt), 32'd1);
    cycle("tp3");
    #1;
    check_eq("tp3_halt_off", 32'(ucarb_halt), 32'd0);
    check_eq("tp3_first", 32'(newLit), 32'hFD);
    pe_newLitAccept = 2'b11;
    cycle("tp3");
    #1; check_eq("tp3_second", 32'(newLit), 32'd7);
    cycle("tp3");
    pe_newLitAccept = 2'b00;

    // Fill the queue, then a pending 9 waits until one pop frees a slot.
    imply2(2'b11, 8'd2, 8'd1);
    #1; check_eq("tp4_rr_order", 32'(newLit), 32'd1);
    imply2(2'b11, 8'd4, 8'd3);
    imply2(2'b01, 8'd0, 8'd9);
    #1; check_eq("tp4_halt_full", 32'(ucarb_halt), 32'd1);
    pe_newLitAccept = 2'b11; #1;
    check_eq("tp4_head", 32'(newLit), 32'd1);
    cycle("tp4");
    pe_newLitAccept = 2'b00; #1;
    check_eq("tp4_halt_rel", 32'(ucarb_halt), 32'd0);
    pe_newLitAccept = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1; check_eq("tp4_order", 32'(newLit), 32'(exp_order[k]));
      cycle("tp4");
    end
    pe_newLitAccept = 2'b00; #1;
    check_eq("tp4_drained", 32'(newLitValid), 32'd0);

    // Conflict with two entries queued, then clear.
    imply2(2'b11, 8'd6, 8'd5);
    pe_conflict = 2'b10;
    cycle("tp5");
    pe_conflict = 2'b00; #1;
    check_eq("tp5_conf", 32'(conflict), 32'd1);
    check_eq("tp5_nlv", 32'(newLitValid), 32'd0);
    cycle("tp5");
    #1; check_eq("tp5_sticky", 32'(conflict), 32'd1);
    conflict_clr = 1'b1;
    cycle("tp5");
    conflict_clr = 1'b0; #1;
    check_eq("tp5_clr", 32'(conflict), 32'd0);
    check_eq("tp5_empty", 32'(quiescent), 32'd1);

    // Duplicate and complementary implications against a queued 4.
    imply2(2'b11, 8'd2, 8'd1);
    imply2(2'b01, 8'd0, 8'd4);
    imply2(2'b01, 8'd0, 8'd4);
    imply2(2'b10, 8'hFC, 8'd0);
    #1;
`ifdef UCARB_DEDUP_EN
    check_eq("tp6_negconf", 32'(conflict), 32'd1);
`else
    check_eq("tp6_noconf", 32'(conflict), 32'd0);
    check_eq("tp6_fullhalt", 32'(ucarb_halt), 32'd1);
`endif
    conflict_clr = 1'b1;
    cycle("tp6");
    conflict_clr = 1'b0;

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n           = ($urandom_range(0, 499) != 0);
      dec_valid       = 1'($urandom_range(0, 1));
      dec_lit         = rand_lit();
      pe_stall        = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      pe_newLitAccept = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      for (int i = 0; i < NP; i++) begin
        pe_imply_valid[i]        = ($urandom_range(0, 3) == 0);
        pe_imply_lit[i*LW +: LW] = rand_lit();
      end
      pe_conflict  = ($urandom_range(0, 99) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      conflict_clr = m_conf ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
